// File: rtl/mem_sys_pkg.sv
// rtl/mem_sys_pkg.sv - shared types and address helper for the unified memory subsystem
package mem_sys_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   typedef enum logic {PORT_I, PORT_D} port_t;

   localparam int MAX_ADDR_W = 64;

   // Byte address to word index; depth is a power of two, so upper bits wrap away.
   function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] addr,
                                                         input int unsigned depth);
      return (addr >> 2) & MAX_ADDR_W'(depth - 1);
   endfunction

endpackage

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-way round-robin arbiter between instruction and data ports
module mem_arb
   import mem_sys_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  i_req,
   input  logic  d_req,
   input  logic  en,
   output logic  grant_valid,
   output port_t grant
);

   port_t last_grant;

   always_comb begin
      grant_valid = en & (i_req | d_req);
      grant       = PORT_I;
      if (i_req && d_req) begin
         grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
      end else if (d_req) begin
         grant = PORT_D;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= PORT_I;
      end else if (grant_valid) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/mem_sys.sv
// rtl/mem_sys.sv - unified word-addressed RAM serving I and D ports with wait states
module mem_sys
   import mem_sys_pkg::*;
#(
   parameter int    ADDR_W      = 32,
   parameter int    DATA_W      = 32,
   parameter int    DEPTH_WORDS = 256,
   parameter int    LATENCY     = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_ready,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [DATA_W/8-1:0] d_be,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ready,
   output logic                busy
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam int         BE_W      = DATA_W / 8;
   localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic              grant_valid;
   port_t             grant;
   port_t             cap_port;
   logic [IDX_W-1:0]  cap_idx;
   logic              cap_we;
   logic [BE_W-1:0]   cap_be;
   logic [DATA_W-1:0] cap_wdata;

   logic [IDX_W-1:0]  i_idx, d_idx;
   port_t             acc_port;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_we;
   logic [BE_W-1:0]   acc_be;
   logic [DATA_W-1:0] acc_wdata;
   logic              commit;

   mem_arb u_arb (
      .clk         (clk),
      .reset       (reset),
      .i_req       (i_req),
      .d_req       (d_req),
      .en          (state == IDLE),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   assign i_idx = IDX_W'(word_index(MAX_ADDR_W'(i_addr), DEPTH_WORDS));
   assign d_idx = IDX_W'(word_index(MAX_ADDR_W'(d_addr), DEPTH_WORDS));

   // With zero wait states the commit edge is the grant edge, so use the live fields.
   always_comb begin
      if (state == IDLE) begin
         acc_port  = grant;
         acc_idx   = (grant == PORT_D) ? d_idx : i_idx;
         acc_we    = (grant == PORT_D) & d_we;
         acc_be    = d_be;
         acc_wdata = d_wdata;
      end else begin
         acc_port  = cap_port;
         acc_idx   = cap_idx;
         acc_we    = cap_we;
         acc_be    = cap_be;
         acc_wdata = cap_wdata;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               state_n = (LATENCY == 0) ? DONE : WAIT;
               cnt_n   = WAIT_INIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_n = DONE;
            else             cnt_n   = cnt - 4'd1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign commit  = (state_n == DONE) && !reset;
   assign busy    = (state != IDLE);
   assign i_ready = (state == DONE) && (cap_port == PORT_I);
   assign d_ready = (state == DONE) && (cap_port == PORT_D);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         cap_port  <= PORT_I;
         cap_idx   <= '0;
         cap_we    <= 1'b0;
         cap_be    <= '0;
         cap_wdata <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (state == IDLE && grant_valid) begin
            cap_port  <= acc_port;
            cap_idx   <= acc_idx;
            cap_we    <= acc_we;
            cap_be    <= acc_be;
            cap_wdata <= acc_wdata;
         end
         if (commit && !acc_we) begin
            if (acc_port == PORT_I) i_rdata <= mem[acc_idx];
            else                    d_rdata <= mem[acc_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit && acc_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_sys.sv
// tb/tb_mem_sys.sv - randomized self-checking bench for mem_sys at latencies 1, 4 and 0
module tb_mem_sys;

   localparam int N     = 3;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst     [N];
   logic        i_req   [N];
   logic [31:0] i_addr  [N];
   logic [31:0] i_rdata [N];
   logic        i_ready [N];
   logic        d_req   [N];
   logic        d_we    [N];
   logic [3:0]  d_be    [N];
   logic [31:0] d_addr  [N];
   logic [31:0] d_wdata [N];
   logic [31:0] d_rdata [N];
   logic        d_ready [N];
   logic        busy    [N];

   int checks   = 0;
   int failures = 0;

   logic [31:0] model    [N][DEPTH];
   logic [31:0] last_drd [N];
   logic [31:0] last_ird [N];
   bit          last_d   [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_sys #(
         .ADDR_W      (32),
         .DATA_W      (32),
         .DEPTH_WORDS (DEPTH),
         .LATENCY     (g == 0 ? 1 : (g == 1 ? 4 : 0)),
         .INIT_FILE   ("")
      ) dut (
         .clk     (clk),
         .reset   (rst[g]),
         .i_req   (i_req[g]),
         .i_addr  (i_addr[g]),
         .i_rdata (i_rdata[g]),
         .i_ready (i_ready[g]),
         .d_req   (d_req[g]),
         .d_we    (d_we[g]),
         .d_be    (d_be[g]),
         .d_addr  (d_addr[g]),
         .d_wdata (d_wdata[g]),
         .d_rdata (d_rdata[g]),
         .d_ready (d_ready[g]),
         .busy    (busy[g])
      );
   end

   function automatic int lat(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input int k);
      @(negedge clk);
      rst[k]   = 1'b1;
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
      @(negedge clk);
      check("rst_i_ready", {31'b0, i_ready[k]}, 32'd0);
      check("rst_d_ready", {31'b0, d_ready[k]}, 32'd0);
      check("rst_busy",    {31'b0, busy[k]},    32'd0);
      check("rst_i_rdata", i_rdata[k], 32'd0);
      check("rst_d_rdata", d_rdata[k], 32'd0);
      rst[k]      = 1'b0;
      last_d[k]   = 1'b0;
      last_drd[k] = '0;
      last_ird[k] = '0;
   endtask

   // Checks returned data against the model and applies writes in completion order.
   task automatic finish_port(input int k, input bit is_d, input bit we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
      int idx;
      idx = widx(addr);
      if (is_d && we) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) model[k][idx][b*8 +: 8] = wdata[b*8 +: 8];
         check("d_rdata_hold", d_rdata[k], last_drd[k]);
      end else if (is_d) begin
         check("d_rdata", d_rdata[k], model[k][idx]);
         last_drd[k] = model[k][idx];
      end else begin
         check("i_rdata", i_rdata[k], model[k][idx]);
         last_ird[k] = model[k][idx];
      end
      if (is_d) check("i_rdata_hold", i_rdata[k], last_ird[k]);
      last_d[k] = is_d;
   endtask

   task automatic access(input int k, input bit is_d, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      bit seen, bad_busy, other;
      if (is_d) begin
         d_req[k] = 1'b1; d_we[k] = we; d_be[k] = be; d_addr[k] = addr; d_wdata[k] = wdata;
      end else begin
         i_req[k] = 1'b1; i_addr[k] = addr;
      end
      n = 0; seen = 0; bad_busy = 0; other = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (!busy[k]) bad_busy = 1;
         if (is_d ? i_ready[k] : d_ready[k]) other = 1;
         seen = is_d ? d_ready[k] : i_ready[k];
      end
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
      check("latency", n, lat(k) + 1);
      check("busy_during", {31'b0, bad_busy}, 32'd0);
      check("other_ready", {31'b0, other}, 32'd0);
      finish_port(k, is_d, we, be, addr, wdata);
      @(negedge clk);
      check("pulse_end", {30'b0, i_ready[k] | d_ready[k], busy[k]}, 32'd0);
   endtask

   task automatic dual(input int k, input bit we, input logic [3:0] be, input logic [31:0] iaddr,
                       input logic [31:0] daddr, input logic [31:0] wdata);
      int n;
      bit seen, win_d;
      i_req[k] = 1'b1; i_addr[k] = iaddr;
      d_req[k] = 1'b1; d_we[k] = we; d_be[k] = be; d_addr[k] = daddr; d_wdata[k] = wdata;
      win_d = !last_d[k];
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         seen = i_ready[k] | d_ready[k];
      end
      check("dual_lat1", n, lat(k) + 1);
      check("dual_port1", {31'b0, d_ready[k]}, {31'b0, win_d});
      if (win_d) begin
         finish_port(k, 1'b1, we, be, daddr, wdata);
         d_req[k] = 1'b0;
      end else begin
         finish_port(k, 1'b0, 1'b0, 4'h0, iaddr, 32'h0);
         i_req[k] = 1'b0;
      end
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         seen = win_d ? i_ready[k] : d_ready[k];
      end
      check("dual_lat2", n, lat(k) + 2);
      if (win_d) finish_port(k, 1'b0, 1'b0, 4'h0, iaddr, 32'h0);
      else       finish_port(k, 1'b1, we, be, daddr, wdata);
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic reset_mid(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                            input int c);
      d_req[k] = 1'b1; d_we[k] = 1'b1; d_be[k] = 4'hf; d_addr[k] = addr; d_wdata[k] = wdata;
      repeat (c) @(negedge clk);
      rst[k] = 1'b1;
      #1;
      check("abort_busy",    {31'b0, busy[k]},    32'd0);
      check("abort_d_ready", {31'b0, d_ready[k]}, 32'd0);
      d_req[k] = 1'b0;
      @(negedge clk);
      rst[k]      = 1'b0;
      last_d[k]   = 1'b0;
      last_drd[k] = '0;
      last_ird[k] = '0;
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         rst[k] = 1'b1; i_req[k] = 1'b0; i_addr[k] = '0;
         d_req[k] = 1'b0; d_we[k] = 1'b0; d_be[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
      end
      for (int k = 0; k < N; k++) begin
         do_reset(k);
         for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] v;
            v = (w == 3) ? 32'h1234_5678 : ((w == 4) ? 32'h1111_1111 : $urandom);
            access(k, 1'b1, 1'b1, 4'hf, 32'(w * 4), v);
         end
         access(k, 1'b0, 1'b0, 4'h0, 32'h0C, 32'h0);
         check("fetch_word3", i_rdata[k], 32'h1234_5678);
         access(k, 1'b1, 1'b1, 4'b0101, 32'h10, 32'hAABB_CCDD);
         access(k, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
         check("lane_merge", d_rdata[k], 32'h11BB_11DD);
         access(k, 1'b1, 1'b1, 4'b0000, 32'h14, 32'hFFFF_FFFF);
         access(k, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
         access(k, 1'b1, 1'b1, 4'hf, 32'h400, 32'hDEAD_BEEF);
         access(k, 1'b1, 1'b0, 4'h0, 32'h000, 32'h0);
         check("wrap_read", d_rdata[k], 32'hDEAD_BEEF);
         access(k, 1'b1, 1'b0, 4'h0, 32'h003, 32'h0);
         check("low_bits", d_rdata[k], 32'hDEAD_BEEF);

         do_reset(k);
         dual(k, 1'b0, 4'h0, 32'h0C, 32'h10, 32'h0);
         dual(k, 1'b0, 4'h0, 32'h0C, 32'h10, 32'h0);

         for (int t = 0; t < 60; t++) begin
            int unsigned r;
            logic [31:0] a1, a2, wd;
            logic [3:0]  be;
            r  = $urandom_range(0, 3);
            a1 = $urandom;
            a2 = (t % 4 == 0) ? a1 : $urandom;
            wd = $urandom;
            be = 4'($urandom_range(0, 15));
            case (r)
               0: access(k, 1'b0, 1'b0, 4'h0, a1, 32'h0);
               1: access(k, 1'b1, 1'b0, 4'h0, a1, 32'h0);
               2: access(k, 1'b1, 1'b1, be, a1, wd);
               default: dual(k, 1'($urandom_range(0, 1)), be, a1, a2, wd);
            endcase
         end

         if (lat(k) >= 1) begin
            reset_mid(k, 32'h20, 32'hCAFE_F00D ^ $urandom, (lat(k) >= 2) ? 2 : 1);
            access(k, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
